alu_op_issue: RTL and testbench

Registered ALU-control stage at the ID/EX boundary of the MIPS pipeline. It decodes the main-control ALUOp class, R-type funct and I-type opcode into the 4-bit operation code and shift amount the EX-stage ALU consumes. It holds on stall, inserts a bubble on flush, and flags and counts illegal encodings for the debug unit.

---
 rtl/alu_op_issue.sv | 150 +++++++++++++++
 tb/tb_alu_op_issue.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_op_issue.sv
// ID/EX ALU-control stage: decodes ALUOp/funct/opcode into an ALU op and shift amount,
// registers it with stall/flush handling, and keeps a saturating count of illegal encodings.
module alu_op_issue #(
  parameter int NBITS   = 32,
  parameter int RNBITS  = 5,
  parameter int BOP     = 4,
  parameter int CNTBITS = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_Valid,
  input  logic [1:0]         i_ALUOp,
  input  logic [5:0]         i_Opcode,
  input  logic [5:0]         i_Funct,
  input  logic [RNBITS-1:0]  i_Shamt,
  input  logic [RNBITS-1:0]  i_RsLow,
  input  logic               i_Stall,
  input  logic               i_Flush,
  input  logic               i_ClearCount,
  output logic [BOP-1:0]     o_Op,
  output logic [RNBITS-1:0]  o_Shamt,
  output logic               o_Valid,
  output logic               o_Illegal,
  output logic [CNTBITS-1:0] o_IllegalCount
);

  localparam logic [BOP-1:0] OP_AND = BOP'(4'b0000);
  localparam logic [BOP-1:0] OP_OR  = BOP'(4'b0001);
  localparam logic [BOP-1:0] OP_ADD = BOP'(4'b0010);
  localparam logic [BOP-1:0] OP_SLL = BOP'(4'b0011);
  localparam logic [BOP-1:0] OP_SRL = BOP'(4'b0100);
  localparam logic [BOP-1:0] OP_SUB = BOP'(4'b0110);
  localparam logic [BOP-1:0] OP_SLT = BOP'(4'b0111);
  localparam logic [BOP-1:0] OP_NOR = BOP'(4'b1100);
  localparam logic [BOP-1:0] OP_XOR = BOP'(4'b1101);

  localparam logic [CNTBITS-1:0] CNT_MAX = {CNTBITS{1'b1}};
  // The forwarded rs value is never narrower than the shift field in a sane configuration.
  localparam int RS_USE = (NBITS >= RNBITS) ? RNBITS : NBITS;

  logic [BOP-1:0]     dec_op;
  logic [RNBITS-1:0]  dec_shamt;
  logic               dec_illegal;
  logic [RNBITS-1:0]  rs_shamt;

  logic [BOP-1:0]     op_q,      op_d;
  logic [RNBITS-1:0]  shamt_q,   shamt_d;
  logic               valid_q,   valid_d;
  logic               illegal_q, illegal_d;
  logic [CNTBITS-1:0] count_q,   count_d;
  logic               count_inc;

  assign rs_shamt = RNBITS'(i_RsLow[RS_USE-1:0]);

  // Decode class/funct/opcode; unknown encodings fall back to ADD with the illegal flag.
  always_comb begin
    dec_op      = OP_ADD;
    dec_shamt   = {RNBITS{1'b0}};
    dec_illegal = 1'b0;
    case (i_ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        case (i_Funct)
          6'b100000, 6'b100001: dec_op = OP_ADD;
          6'b100010, 6'b100011: dec_op = OP_SUB;
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b100110: dec_op = OP_XOR;
          6'b100111: dec_op = OP_NOR;
          6'b101010: dec_op = OP_SLT;
          6'b000000: begin dec_op = OP_SLL; dec_shamt = i_Shamt;  end
          6'b000010: begin dec_op = OP_SRL; dec_shamt = i_Shamt;  end
          6'b000100: begin dec_op = OP_SLL; dec_shamt = rs_shamt; end
          6'b000110: begin dec_op = OP_SRL; dec_shamt = rs_shamt; end
          default:   dec_illegal = 1'b1;
        endcase
      end
      2'b11: begin
        case (i_Opcode)
          6'b001000, 6'b001001: dec_op = OP_ADD;
          6'b001100: dec_op = OP_AND;
          6'b001101: dec_op = OP_OR;
          6'b001110: dec_op = OP_XOR;
          6'b001010: dec_op = OP_SLT;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_op = OP_ADD;
    endcase
  end

  // Capture priority: flush bubble, then stall hold, then idle bubble, then capture.
  always_comb begin
    op_d      = op_q;
    shamt_d   = shamt_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    count_inc = 1'b0;
    if (i_Flush || (!i_Stall && !i_Valid)) begin
      op_d      = OP_AND;
      shamt_d   = {RNBITS{1'b0}};
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (i_Stall) begin
      op_d      = op_q;
    end else begin
      op_d      = dec_op;
      shamt_d   = dec_shamt;
      valid_d   = 1'b1;
      illegal_d = dec_illegal;
      count_inc = dec_illegal;
    end
  end

  // Saturating illegal counter; clear wins over a same-cycle increment.
  always_comb begin
    if (i_ClearCount) begin
      count_d = {CNTBITS{1'b0}};
    end else if (count_inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNTBITS'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      op_q      <= OP_AND;
      shamt_q   <= {RNBITS{1'b0}};
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= {CNTBITS{1'b0}};
    end else begin
      op_q      <= op_d;
      shamt_q   <= shamt_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign o_Op           = op_q;
  assign o_Shamt        = shamt_q;
  assign o_Valid        = valid_q;
  assign o_Illegal      = illegal_q;
  assign o_IllegalCount = count_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed-vector bench for alu_op_issue with hand-computed expectations.
module tb_alu_op_issue;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [1:0] aluop;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] shamt_in;
  logic [4:0] rslow;
  logic       stall;
  logic       flush;
  logic       clr;
  logic [3:0] op;
  logic [4:0] shamt;
  logic       ovalid;
  logic       illegal;
  logic [7:0] cnt;

  int n_vec  = 0;
  int n_miss = 0;

  alu_op_issue dut (
    .i_clk(clk), .i_reset(rst_n), .i_Valid(valid), .i_ALUOp(aluop),
    .i_Opcode(opcode), .i_Funct(funct), .i_Shamt(shamt_in), .i_RsLow(rslow),
    .i_Stall(stall), .i_Flush(flush), .i_ClearCount(clr),
    .o_Op(op), .o_Shamt(shamt), .o_Valid(ovalid), .o_Illegal(illegal),
    .o_IllegalCount(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_op, input logic [4:0] e_sh,
                         input logic e_v, input logic e_ill, input logic [7:0] e_cnt);
    chk({tag, ".op"},    32'(op),      32'(e_op));
    chk({tag, ".shamt"}, 32'(shamt),   32'(e_sh));
    chk({tag, ".valid"}, 32'(ovalid),  32'(e_v));
    chk({tag, ".ill"},   32'(illegal), 32'(e_ill));
    chk({tag, ".cnt"},   32'(cnt),     32'(e_cnt));
  endtask

  // aluop, opcode, funct, expected op, expected shamt (i_Shamt=9, i_RsLow=3 during sweep)
  typedef struct { logic [1:0] a; logic [5:0] oc; logic [5:0] fn; logic [3:0] eo; logic [4:0] es; } vec_t;
  vec_t sweep[8] = '{
    '{2'b00, 6'b000000, 6'b000000, 4'b0010, 5'd0},
    '{2'b01, 6'b000000, 6'b000000, 4'b0110, 5'd0},
    '{2'b11, 6'b001110, 6'b000000, 4'b1101, 5'd0},
    '{2'b10, 6'b000000, 6'b100111, 4'b1100, 5'd0},
    '{2'b10, 6'b000000, 6'b101010, 4'b0111, 5'd0},
    '{2'b11, 6'b001010, 6'b000000, 4'b0111, 5'd0},
    '{2'b10, 6'b000000, 6'b000100, 4'b0011, 5'd3},
    '{2'b10, 6'b000000, 6'b000010, 4'b0100, 5'd9}
  };

  initial begin
    rst_n = 1'b0; valid = 1'b0; aluop = 2'b00; opcode = 6'd0; funct = 6'd0;
    shamt_in = 5'd0; rslow = 5'd0; stall = 1'b0; flush = 1'b0; clr = 1'b0;
    step(); step();
    chk_all("reset", 4'd0, 5'd0, 1'b0, 1'b0, 8'd0);

    rst_n = 1'b1;
    step();
    chk_all("idle", 4'd0, 5'd0, 1'b0, 1'b0, 8'd0);

    valid = 1'b1; aluop = 2'b10; funct = 6'b000000; shamt_in = 5'd7;
    step();
    chk_all("sll_imm", 4'b0011, 5'd7, 1'b1, 1'b0, 8'd0);
    funct = 6'b000110; rslow = 5'd19;
    step();
    chk_all("srl_var", 4'b0100, 5'd19, 1'b1, 1'b0, 8'd0);

    shamt_in = 5'd9; rslow = 5'd3;
    for (int i = 0; i < 8; i++) begin
      aluop = sweep[i].a; opcode = sweep[i].oc; funct = sweep[i].fn;
      step();
      chk_all($sformatf("sweep%0d", i), sweep[i].eo, sweep[i].es, 1'b1, 1'b0, 8'd0);
    end

    aluop = 2'b10; funct = 6'b100110;
    step();
    chk_all("xor_cap", 4'b1101, 5'd0, 1'b1, 1'b0, 8'd0);
    stall = 1'b1; funct = 6'b100100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("stall%0d", i), 4'b1101, 5'd0, 1'b1, 1'b0, 8'd0);
    end
    flush = 1'b1;
    step();
    chk_all("flush_stall", 4'd0, 5'd0, 1'b0, 1'b0, 8'd0);
    flush = 1'b0; stall = 1'b0;

    funct = 6'b111111;
    step();
    chk_all("ill_first", 4'b0010, 5'd0, 1'b1, 1'b1, 8'd1);
    for (int i = 1; i < 300; i++) step();
    chk_all("ill_sat", 4'b0010, 5'd0, 1'b1, 1'b1, 8'd255);
    clr = 1'b1;
    step();
    chk_all("clear_win", 4'b0010, 5'd0, 1'b1, 1'b1, 8'd0);
    clr = 1'b0;
    aluop = 2'b11; opcode = 6'b000000;
    step();
    chk_all("ill_imm", 4'b0010, 5'd0, 1'b1, 1'b1, 8'd1);

    flush = 1'b1;
    step();
    chk_all("ill_flush", 4'd0, 5'd0, 1'b0, 1'b0, 8'd1);
    flush = 1'b0; stall = 1'b1;
    step();
    chk_all("ill_stall", 4'd0, 5'd0, 1'b0, 1'b0, 8'd1);
    stall = 1'b0; valid = 1'b0;
    step();
    chk_all("ill_idle", 4'd0, 5'd0, 1'b0, 1'b0, 8'd1);

    valid = 1'b1; aluop = 2'b10; funct = 6'b000000; shamt_in = 5'd21;
    step();
    chk_all("pre_rst", 4'b0011, 5'd21, 1'b1, 1'b0, 8'd1);
    stall = 1'b1;
    step();
    chk_all("held", 4'b0011, 5'd21, 1'b1, 1'b0, 8'd1);
    rst_n = 1'b0;
    step();
    chk_all("rst_stall", 4'd0, 5'd0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1; stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
